exec_sequencer: RTL and testbench

- Multi-cycle control FSM for the RV64 core. Sequences each instruction through fetch, execute, memory and writeback.
- Starts IFU fetches and waits for instruction arrival, the ALU result and data-side AXI read/write completion.
- Generates the single-cycle PC-advance, register-writeback and instruction-complete strobes.
- Replaces the free-running INSTR_Complete / hard-wired ALU_MEM_Finish arrangement in top.

---
 rtl/seq_pkg.sv | 26 ++
 rtl/seq_watchdog.sv | 37 +++
 rtl/exec_sequencer.sv | 154 +++++++++++++++
 tb/tb_exec_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the exec_sequencer control FSM.
package seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_MEM   = 3'd3,
        ST_WB    = 3'd4,
        ST_TRAP  = 3'd5
    } seq_state_e;

    localparam logic [1:0] TRAP_NONE    = 2'd0;
    localparam logic [1:0] TRAP_ILLEGAL = 2'd1;
    localparam logic [1:0] TRAP_TIMEOUT = 2'd2;

    // States that wait on an external agent and are therefore guarded by the watchdog.
    function automatic logic is_waiting(input seq_state_e s);
        return (s == ST_FETCH) || (s == ST_EXEC) || (s == ST_MEM);
    endfunction

    function automatic logic is_busy(input seq_state_e s);
        return is_waiting(s) || (s == ST_WB);
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Per-state cycle counter; flags expiry on the TIMEOUT-th cycle spent in a waiting state.
module seq_watchdog #(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_W   = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count_en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = count_en && (cnt_q == LIMIT);

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle FETCH/EXEC/MEM/WB sequencer for the RV64 core with trap and watchdog.
// Define SEQ_PERF_CNT_EN to build the cycle_cnt / instret_cnt performance counters.
module exec_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_W   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_arrive,
    input  logic        dec_mem_en,
    input  logic        dec_mem_wr,
    input  logic        dec_reg_wen,
    input  logic        dec_illegal,
    input  logic        alu_done,
    input  logic        mem_done,
    output logic        fetch_req,
    output logic        mem_req,
    output logic        mem_wr,
    output logic        reg_wen,
    output logic        pc_en,
    output logic        instr_complete,
    output logic        busy,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [2:0]  state_dbg,
    output logic [63:0] cycle_cnt,
    output logic [63:0] instret_cnt
);

    seq_state_e  state_q, state_d;
    logic        fetch_req_q, fetch_req_d;
    logic        mem_wr_q, mem_wr_d;
    logic        reg_wen_q, reg_wen_d;
    logic [1:0]  trap_cause_q, trap_cause_d;
    logic        state_change;
    logic        wd_expired;

    seq_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clear    (state_change),
        .count_en (is_waiting(state_q)),
        .expired  (wd_expired)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        trap_cause_d = trap_cause_q;
        unique case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: begin
                if (instr_arrive) begin
                    state_d = ST_EXEC;
                end else if (wd_expired) begin
                    state_d      = ST_TRAP;
                    trap_cause_d = TRAP_TIMEOUT;
                end
            end
            ST_EXEC: begin
                if (dec_illegal) begin
                    state_d      = ST_TRAP;
                    trap_cause_d = TRAP_ILLEGAL;
                end else if (alu_done) begin
                    state_d = dec_mem_en ? ST_MEM : ST_WB;
                end else if (wd_expired) begin
                    state_d      = ST_TRAP;
                    trap_cause_d = TRAP_TIMEOUT;
                end
            end
            ST_MEM: begin
                if (mem_done) begin
                    state_d = ST_WB;
                end else if (wd_expired) begin
                    state_d      = ST_TRAP;
                    trap_cause_d = TRAP_TIMEOUT;
                end
            end
            ST_WB:   state_d = ST_FETCH;
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_IDLE;
        endcase

        state_change = (state_d != state_q);

        // Strobes that depend on decoder inputs are captured on the entering edge
        // so the outputs stay free of combinational input paths.
        fetch_req_d = state_change && (state_d == ST_FETCH);
        mem_wr_d    = 1'b0;
        if (state_d == ST_MEM) begin
            mem_wr_d = state_change ? dec_mem_wr : mem_wr_q;
        end
        reg_wen_d = (state_d == ST_WB) && dec_reg_wen && !dec_mem_wr;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            fetch_req_q  <= 1'b0;
            mem_wr_q     <= 1'b0;
            reg_wen_q    <= 1'b0;
            trap_cause_q <= TRAP_NONE;
        end else begin
            state_q      <= state_d;
            fetch_req_q  <= fetch_req_d;
            mem_wr_q     <= mem_wr_d;
            reg_wen_q    <= reg_wen_d;
            trap_cause_q <= trap_cause_d;
        end
    end

    assign fetch_req      = fetch_req_q;
    assign mem_req        = (state_q == ST_MEM);
    assign mem_wr         = mem_wr_q;
    assign reg_wen        = reg_wen_q;
    assign pc_en          = (state_q == ST_WB);
    assign instr_complete = (state_q == ST_WB);
    assign busy           = is_busy(state_q);
    assign trap           = (state_q == ST_TRAP);
    assign trap_cause     = trap_cause_q;
    assign state_dbg      = state_q;

`ifdef SEQ_PERF_CNT_EN
    logic [63:0] cycle_cnt_q, cycle_cnt_d;
    logic [63:0] instret_cnt_q, instret_cnt_d;

    always_comb begin
        cycle_cnt_d   = cycle_cnt_q + {63'd0, busy};
        instret_cnt_d = instret_cnt_q + {63'd0, instr_complete};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer: vector table plus hand-written trap/timeout/reset sequences.
module tb_exec_sequencer;

    // Input vector fields: rst, instr_arrive, dec_mem_en, dec_mem_wr, dec_reg_wen, dec_illegal, alu_done, mem_done
    typedef struct packed {
        logic rst, ia, me, mw, rw, il, ad, md;
    } ins_t;

    typedef struct packed {
        logic [2:0] st;
        logic       fr, mr, mw, rw, pe, ic, bz, tr;
        logic [1:0] tc;
    } outs_t;

    typedef struct {
        string name;
        ins_t  i;
        outs_t o;
    } vec_t;

    localparam ins_t RST0     = 8'b0000_0000;
    localparam ins_t NM       = 8'b1100_1010;
    localparam ins_t LD       = 8'b1110_1010;
    localparam ins_t LD_DONE  = 8'b1110_1011;
    localparam ins_t LD_RST   = 8'b0110_1010;
    localparam ins_t ST       = 8'b1111_1010;
    localparam ins_t ST_DONE  = 8'b1111_1011;
    localparam ins_t STRAY    = 8'b1000_0011;
    localparam ins_t NM_NORW  = 8'b1100_0010;
    localparam ins_t ILL      = 8'b1100_1110;
    localparam ins_t ALL1     = 8'b1111_1111;
    localparam ins_t IDLE_IN  = 8'b1000_0000;

`ifdef SEQ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, instr_arrive, dec_mem_en, dec_mem_wr, dec_reg_wen, dec_illegal, alu_done, mem_done;
    logic        fetch_req, mem_req, mem_wr, reg_wen, pc_en, instr_complete, busy, trap;
    logic [1:0]  trap_cause;
    logic [2:0]  state_dbg;
    logic [63:0] cycle_cnt, instret_cnt;

    always #5 clk = ~clk;

    exec_sequencer #(
        .TIMEOUT (8),
        .CNT_W   (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .instr_arrive   (instr_arrive),
        .dec_mem_en     (dec_mem_en),
        .dec_mem_wr     (dec_mem_wr),
        .dec_reg_wen    (dec_reg_wen),
        .dec_illegal    (dec_illegal),
        .alu_done       (alu_done),
        .mem_done       (mem_done),
        .fetch_req      (fetch_req),
        .mem_req        (mem_req),
        .mem_wr         (mem_wr),
        .reg_wen        (reg_wen),
        .pc_en          (pc_en),
        .instr_complete (instr_complete),
        .busy           (busy),
        .trap           (trap),
        .trap_cause     (trap_cause),
        .state_dbg      (state_dbg),
        .cycle_cnt      (cycle_cnt),
        .instret_cnt    (instret_cnt)
    );

    int    n_tests = 0;
    int    n_fail  = 0;
    vec_t  vecs[$];
    outs_t sb_q[$];
    string sb_name[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected output bundle; strobes tied to a state follow directly from the state number.
    function automatic outs_t eo(input int st, input logic fr, input logic mw, input logic rw,
                                 input logic [1:0] tc);
        outs_t o;
        o.st = 3'(st);
        o.fr = fr;
        o.mr = (st == 3);
        o.mw = mw;
        o.rw = rw;
        o.pe = (st == 4);
        o.ic = (st == 4);
        o.bz = (st >= 1) && (st <= 4);
        o.tr = (st == 5);
        o.tc = tc;
        return o;
    endfunction

    function automatic void add(input string n, input ins_t i, input outs_t o);
        vec_t v;
        v.name = n;
        v.i    = i;
        v.o    = o;
        vecs.push_back(v);
    endfunction

    task automatic drive(input ins_t i);
        rst          = i.rst;
        instr_arrive = i.ia;
        dec_mem_en   = i.me;
        dec_mem_wr   = i.mw;
        dec_reg_wen  = i.rw;
        dec_illegal  = i.il;
        alu_done     = i.ad;
        mem_done     = i.md;
    endtask

    // Drive one cycle of inputs, queue the expected post-edge outputs, then compare.
    task automatic step(input string name, input ins_t i, input outs_t o);
        outs_t act;
        outs_t exp;
        @(negedge clk);
        drive(i);
        sb_q.push_back(o);
        sb_name.push_back(name);
        @(posedge clk);
        #1;
        act = {state_dbg, fetch_req, mem_req, mem_wr, reg_wen, pc_en, instr_complete, busy, trap, trap_cause};
        exp = sb_q.pop_front();
        check(sb_name.pop_front(), 64'(act), 64'(exp));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        drive(RST0);
        repeat (2) @(posedge clk);

        add("reset_state", RST0,    eo(0, 0, 0, 0, 0));
        add("nm_fetch0",   NM,      eo(1, 1, 0, 0, 0));
        add("nm_exec0",    NM,      eo(2, 0, 0, 0, 0));
        add("nm_wb0",      NM,      eo(4, 0, 0, 1, 0));
        add("nm_fetch1",   NM,      eo(1, 1, 0, 0, 0));
        add("nm_exec1",    NM,      eo(2, 0, 0, 0, 0));
        add("nm_wb1",      NM,      eo(4, 0, 0, 1, 0));
        add("ld_fetch",    LD,      eo(1, 1, 0, 0, 0));
        add("ld_exec",     LD,      eo(2, 0, 0, 0, 0));
        add("ld_mem1",     LD,      eo(3, 0, 0, 0, 0));
        add("ld_mem2",     LD,      eo(3, 0, 0, 0, 0));
        add("ld_mem3",     LD,      eo(3, 0, 0, 0, 0));
        add("ld_mem4",     LD,      eo(3, 0, 0, 0, 0));
        add("ld_mem5",     LD,      eo(3, 0, 0, 0, 0));
        add("ld_wb",       LD_DONE, eo(4, 0, 0, 1, 0));
        add("st_fetch",    ST,      eo(1, 1, 0, 0, 0));
        add("st_exec",     ST,      eo(2, 0, 0, 0, 0));
        add("st_mem1",     ST,      eo(3, 0, 1, 0, 0));
        add("st_mem2",     ST,      eo(3, 0, 1, 0, 0));
        add("st_wb",       ST_DONE, eo(4, 0, 0, 0, 0));
        add("stray_fetch", STRAY,   eo(1, 1, 0, 0, 0));
        add("stray_wait",  STRAY,   eo(1, 0, 0, 0, 0));
        add("norw_exec",   NM_NORW, eo(2, 0, 0, 0, 0));
        add("norw_wb",     NM_NORW, eo(4, 0, 0, 0, 0));
        add("ill_fetch",   ILL,     eo(1, 1, 0, 0, 0));
        add("ill_exec",    ILL,     eo(2, 0, 0, 0, 0));
        add("ill_trap",    ILL,     eo(5, 0, 0, 0, 1));

        foreach (vecs[k]) begin
            step(vecs[k].name, vecs[k].i, vecs[k].o);
        end

        // Trap is terminal: no strobes regardless of inputs until reset.
        for (int k = 0; k < 100; k++) begin
            step("trap_hold", ALL1, eo(5, 0, 0, 0, 1));
        end
        step("trap_reset", RST0, eo(0, 0, 0, 0, 0));

        // FETCH timeout: 8 waiting cycles, then TRAP with cause 2.
        step("to_fetch_first", IDLE_IN, eo(1, 1, 0, 0, 0));
        for (int k = 0; k < 7; k++) begin
            step("to_fetch_wait", IDLE_IN, eo(1, 0, 0, 0, 0));
        end
        step("to_fetch_trap", IDLE_IN, eo(5, 0, 0, 0, 2));
        step("to_reset", RST0, eo(0, 0, 0, 0, 0));

        // Arrival in the expiry cycle wins; then an EXEC timeout with alu_done held low.
        step("tie_fetch_first", IDLE_IN, eo(1, 1, 0, 0, 0));
        for (int k = 0; k < 7; k++) begin
            step("tie_fetch_wait", IDLE_IN, eo(1, 0, 0, 0, 0));
        end
        step("tie_exec", NM_NORW, eo(2, 0, 0, 0, 0));
        for (int k = 0; k < 7; k++) begin
            step("exec_wait", IDLE_IN, eo(2, 0, 0, 0, 0));
        end
        step("exec_timeout", IDLE_IN, eo(5, 0, 0, 0, 2));
        step("exec_to_reset", RST0, eo(0, 0, 0, 0, 0));

        // Reset in the middle of a memory transfer.
        step("rm_fetch0", NM, eo(1, 1, 0, 0, 0));
        step("rm_exec0",  NM, eo(2, 0, 0, 0, 0));
        step("rm_wb0",    NM, eo(4, 0, 0, 1, 0));
        step("rm_fetch1", LD, eo(1, 1, 0, 0, 0));
        step("rm_exec1",  LD, eo(2, 0, 0, 0, 0));
        step("rm_mem1",   LD, eo(3, 0, 0, 0, 0));
        step("rm_mem2",   LD, eo(3, 0, 0, 0, 0));
        check("perf_cycle_before_rst",   cycle_cnt,   PERF ? 64'd6 : 64'd0);
        check("perf_instret_before_rst", instret_cnt, PERF ? 64'd1 : 64'd0);
        step("rm_reset", LD_RST, eo(0, 0, 0, 0, 0));
        check("perf_cycle_after_rst",   cycle_cnt,   64'd0);
        check("perf_instret_after_rst", instret_cnt, 64'd0);
        step("rm_refetch", LD, eo(1, 1, 0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
